// File: rtl/nibbler_ram_pkg.sv
// Shared types and constants for the Nibbler 4096x4 RAM arbiter.
package nibbler_ram_pkg;

    localparam int RAM_AW = 12;
    localparam int RAM_DW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } ram_arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    function automatic logic [1:0] port_mask(input logic port);
        return (port == PORT_LDR) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selector for the two RAM requesters.
// RAM_ARB_RR_EN selects round-robin tie breaking; otherwise the CPU port has fixed priority.
module ram_arb_pick
    import nibbler_ram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] excl,
    output logic       gnt,
    output logic       gnt_vld
);

    logic [1:0] cand;

    assign cand    = req & ~excl;
    assign gnt_vld = |cand;

`ifdef RAM_ARB_RR_EN
    always_comb begin
        if (&cand)
            gnt = ~last;
        else if (cand[0])
            gnt = PORT_CPU;
        else
            gnt = PORT_LDR;
    end
`else
    logic unused_last;
    assign unused_last = last;
    assign gnt = cand[0] ? PORT_CPU : PORT_LDR;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter and SETUP/STROBE/HOLD sequencer for the Nibbler asynchronous RAM.
// Define RAM_ARB_RR_EN for round-robin tie breaking (default: CPU fixed priority).
module ram_arbiter
    import nibbler_ram_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [RAM_DW-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [RAM_DW-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [RAM_AW-1:0] ldr_addr,
    input  logic [RAM_DW-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [RAM_DW-1:0] ldr_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_n_cs,
    output logic              ram_n_we,
    output logic [RAM_DW-1:0] ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [RAM_DW-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES);

    ram_arb_state_t    state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              cur_port, cur_we, last_port;
    logic              grant;
    logic [1:0]        pick_excl;
    logic              pick_gnt, pick_vld;
    logic              pick_we;
    logic [RAM_AW-1:0] pick_addr;
    logic [RAM_DW-1:0] pick_wdata;
    logic              nxt_we, n_cs_d, n_we_d, oe_d, busy_d;
    logic              cpu_ack_d, ldr_ack_d, rd_capture;

    // In HOLD the port just served is masked so only the other one can chain in.
    assign pick_excl = (state == HOLD) ? port_mask(cur_port) : 2'b00;

    ram_arb_pick u_pick (
        .req     ({ldr_req, cpu_req}),
        .last    (last_port),
        .excl    (pick_excl),
        .gnt     (pick_gnt),
        .gnt_vld (pick_vld)
    );

    assign pick_we    = (pick_gnt == PORT_LDR) ? ldr_we    : cpu_we;
    assign pick_addr  = (pick_gnt == PORT_LDR) ? ldr_addr  : cpu_addr;
    assign pick_wdata = (pick_gnt == PORT_LDR) ? ldr_wdata : cpu_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        grant   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_d = SETUP;
                    grant   = 1'b1;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = STROBE_LOAD;
            end
            STROBE: begin
                if (cnt == 4'd1)
                    state_d = HOLD;
                else
                    cnt_d = cnt - 4'd1;
            end
            HOLD: begin
                if (pick_vld) begin
                    state_d = SETUP;
                    grant   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        nxt_we     = grant ? pick_we : cur_we;
        busy_d     = (state_d != IDLE);
        oe_d       = busy_d && nxt_we;
        n_cs_d     = (state_d != STROBE);
        n_we_d     = !((state_d == STROBE) && nxt_we);
        cpu_ack_d  = (state_d == HOLD) && (cur_port == PORT_CPU);
        ldr_ack_d  = (state_d == HOLD) && (cur_port == PORT_LDR);
        rd_capture = (state == STROBE) && (state_d == HOLD) && !cur_we;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_port     <= PORT_CPU;
            cur_we       <= 1'b0;
            last_port    <= PORT_LDR;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_wdata_oe <= 1'b0;
            ram_n_cs     <= 1'b1;
            ram_n_we     <= 1'b1;
            cpu_ack      <= 1'b0;
            ldr_ack      <= 1'b0;
            busy         <= 1'b0;
            cpu_rdata    <= '0;
            ldr_rdata    <= '0;
        end else begin
            if (grant) begin
                cur_port  <= pick_gnt;
                cur_we    <= pick_we;
                last_port <= pick_gnt;
                ram_addr  <= pick_addr;
                ram_wdata <= pick_wdata;
            end
            if (rd_capture) begin
                if (cur_port == PORT_LDR)
                    ldr_rdata <= ram_rdata;
                else
                    cpu_rdata <= ram_rdata;
            end
            ram_wdata_oe <= oe_d;
            ram_n_cs     <= n_cs_d;
            ram_n_we     <= n_we_d;
            cpu_ack      <= cpu_ack_d;
            ldr_ack      <= ldr_ack_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: S=1 instance with a behavioural RAM, plus an S=3 instance.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
    logic [11:0] cpu_addr = 0, ldr_addr = 0;
    logic [3:0]  cpu_wdata = 0, ldr_wdata = 0;
    logic        cpu_ack, ldr_ack, ram_n_cs, ram_n_we, ram_wdata_oe, busy;
    logic [3:0]  cpu_rdata, ldr_rdata, ram_wdata, ram_rdata;
    logic [11:0] ram_addr;

    logic        s3_cpu_req = 0, s3_cpu_we = 0;
    logic [11:0] s3_cpu_addr = 0;
    logic [3:0]  s3_cpu_wdata = 0;
    logic        s3_cpu_ack, s3_ldr_ack, s3_n_cs, s3_n_we, s3_oe, s3_busy;
    logic [3:0]  s3_cpu_rdata, s3_ldr_rdata, s3_wdata;
    logic [11:0] s3_addr;

    logic [3:0]  mem [0:4095];
    int          n_checks = 0, n_fail = 0, bad_we = 0;

    int          cs_low, nwe_low, oe_cnt, addr_oe, first_cack, first_lack, ack_code, ack_n;
    logic [3:0]  cpu_rd_at_ack, ldr_rd_at_ack;
    logic [11:0] tgt_addr;

    always #5 clk = ~clk;

    ram_arbiter #(.STROBE_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_addr(ram_addr), .ram_n_cs(ram_n_cs), .ram_n_we(ram_n_we),
        .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    ram_arbiter #(.STROBE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(s3_cpu_req), .cpu_we(s3_cpu_we), .cpu_addr(s3_cpu_addr), .cpu_wdata(s3_cpu_wdata),
        .cpu_ack(s3_cpu_ack), .cpu_rdata(s3_cpu_rdata),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(12'h000), .ldr_wdata(4'h0),
        .ldr_ack(s3_ldr_ack), .ldr_rdata(s3_ldr_rdata),
        .ram_addr(s3_addr), .ram_n_cs(s3_n_cs), .ram_n_we(s3_n_we),
        .ram_wdata(s3_wdata), .ram_wdata_oe(s3_oe), .ram_rdata(4'h0),
        .busy(s3_busy)
    );

    // Behavioural asynchronous RAM: write commits on the rising edge of n_we.
    assign ram_rdata = ram_n_cs ? 4'h0 : mem[ram_addr];
    always @(posedge ram_n_we) if (!reset) mem[ram_addr] <= ram_wdata;

    always @(negedge clk) begin
        if (!ram_n_we && ram_n_cs) bad_we++;
        if (!s3_n_we && s3_n_cs) bad_we++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample n cycles after the request edge; optionally drop a port's req on its ack.
    task automatic capture(input int n, input bit drop);
        cs_low = 0; nwe_low = 0; oe_cnt = 0; addr_oe = 0;
        first_cack = -1; first_lack = -1; ack_code = 0; ack_n = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (!ram_n_cs) cs_low++;
            if (!ram_n_we) nwe_low++;
            if (ram_wdata_oe) oe_cnt++;
            if (ram_wdata_oe && ram_addr == tgt_addr) addr_oe++;
            if (cpu_ack) begin
                if (first_cack < 0) first_cack = k;
                cpu_rd_at_ack = cpu_rdata;
                ack_code = ack_code * 2; ack_n++;
                if (drop) cpu_req = 1'b0;
            end
            if (ldr_ack) begin
                if (first_lack < 0) first_lack = k;
                ldr_rd_at_ack = ldr_rdata;
                ack_code = ack_code * 2 + 1; ack_n++;
                if (drop) ldr_req = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c3_cs, c3_ack, s3_acks;
        for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_n_cs", ram_n_cs, 1);
        check("rst_n_we", ram_n_we, 1);
        check("rst_oe", ram_wdata_oe, 0);
        check("rst_acks", {cpu_ack, ldr_ack}, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        reset = 1'b0;
        @(negedge clk);

        // CPU write 0x3A5 <- 0xC
        cpu_we = 1; cpu_addr = 12'h3A5; cpu_wdata = 4'hC; cpu_req = 1; tgt_addr = 12'h3A5;
        capture(5, 1);
        check("wr_cs_cycles", cs_low, 1);
        check("wr_nwe_cycles", nwe_low, 1);
        check("wr_oe_cycles", oe_cnt, 3);
        check("wr_addr_cycles", addr_oe, 3);
        check("wr_ack_latency", first_cack, 3);
        check("wr_no_ldr_ack", first_lack, -1);
        check("wr_mem", mem[12'h3A5], 4'hC);

        // Loader read 0x3A5
        ldr_we = 0; ldr_addr = 12'h3A5; ldr_req = 1;
        capture(5, 1);
        check("rd_ack_latency", first_lack, 3);
        check("rd_data", ldr_rd_at_ack, 4'hC);
        check("rd_oe_cycles", oe_cnt, 0);
        check("rd_cs_cycles", cs_low, 1);
        check("rd_nwe_cycles", nwe_low, 0);

        // Simultaneous writes; last served is the loader, so CPU goes first in both modes
        cpu_we = 1; cpu_addr = 12'h001; cpu_wdata = 4'h5;
        ldr_we = 1; ldr_addr = 12'h002; ldr_wdata = 4'hA;
        cpu_req = 1; ldr_req = 1; tgt_addr = 12'hFFF;
        capture(8, 1);
        check("sim_cpu_ack", first_cack, 3);
        check("sim_ldr_ack", first_lack, 6);
        check("sim_mem1", mem[12'h001], 4'h5);
        check("sim_mem2", mem[12'h002], 4'hA);

        // Four rounds of permanent read requests alternate through HOLD->SETUP
        cpu_we = 0; cpu_addr = 12'h001; ldr_we = 0; ldr_addr = 12'h002;
        cpu_req = 1; ldr_req = 1;
        capture(13, 0);
        check("perm_ack_count", ack_n, 4);
        check("perm_ack_order", ack_code, 32'b0101);
        check("perm_first_ack", first_cack, 3);
        cpu_req = 0; ldr_req = 0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("perm_drain", busy, 0);
        @(negedge clk);

        // CPU read 0x001 alone
        cpu_we = 0; cpu_addr = 12'h001; cpu_req = 1;
        capture(5, 1);
        check("cpu_rd_latency", first_cack, 3);
        check("cpu_rd_data", cpu_rd_at_ack, 4'h5);

        // Tie from IDLE with the CPU served last
        cpu_we = 0; cpu_addr = 12'h002; ldr_we = 0; ldr_addr = 12'h001;
        cpu_req = 1; ldr_req = 1;
        capture(8, 1);
`ifdef RAM_ARB_RR_EN
        check("tie_ldr_ack", first_lack, 3);
        check("tie_cpu_ack", first_cack, 6);
`else
        check("tie_cpu_ack", first_cack, 3);
        check("tie_ldr_ack", first_lack, 6);
`endif
        check("tie_cpu_data", cpu_rd_at_ack, 4'hA);
        check("tie_ldr_data", ldr_rd_at_ack, 4'h5);

        // STROBE_CYCLES=3 write
        s3_cpu_we = 1; s3_cpu_addr = 12'h7F0; s3_cpu_wdata = 4'h3; s3_cpu_req = 1;
        c3_cs = 0; c3_ack = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!s3_n_cs) c3_cs++;
            if (s3_cpu_ack) begin
                if (c3_ack < 0) c3_ack = k;
                s3_cpu_req = 0;
            end
        end
        check("s3_cs_cycles", c3_cs, 3);
        check("s3_ack_latency", c3_ack, 5);

        // Async reset in the second STROBE cycle
        s3_cpu_addr = 12'h7F1; s3_cpu_wdata = 4'h6; s3_cpu_req = 1;
        repeat (3) @(negedge clk);
        check("s3_strobe2_cs", s3_n_cs, 0);
        reset = 1'b1; s3_cpu_req = 0;
        #1;
        check("s3_rst_n_cs", s3_n_cs, 1);
        check("s3_rst_n_we", s3_n_we, 1);
        check("s3_rst_oe", s3_oe, 0);
        check("s3_rst_ack", s3_cpu_ack, 0);
        check("s3_rst_busy", s3_busy, 0);
        s3_acks = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (s3_cpu_ack || s3_ldr_ack) s3_acks++;
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (s3_cpu_ack || s3_ldr_ack) s3_acks++;
        end
        check("s3_abort_no_ack", s3_acks, 0);
        check("s3_post_rst_idle", s3_busy, 0);
        check("s3_post_rst_cs", s3_n_cs, 1);

        check("we_without_cs", bad_we, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
